dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 84 ++++++++
 tb/tb_dram_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter granting N_REQ requesters one at a time onto a single DRAM adapter.
// Ports: clk/reset (async, active-high); req_addr/req_wdata (N_REQ slots of AW bits), req_re/req_we
// (level requests), req_rdata (broadcast read data), req_valid (one-cycle completion per requester);
// dramAddress/dramWriteData/dramReadEnable/dramWriteEnable to the adapter, dramReadData/dramValid back;
// grant_id (current or last grant), busy (BUSY or RELEASE).
module dram_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*AW-1:0] req_wdata,
  input  logic [N_REQ-1:0]   req_re,
  input  logic [N_REQ-1:0]   req_we,
  output logic [AW-1:0]      req_rdata,
  output logic [N_REQ-1:0]   req_valid,
  output logic [AW-1:0]      dramAddress,
  output logic [AW-1:0]      dramWriteData,
  output logic               dramReadEnable,
  output logic               dramWriteEnable,
  input  logic [AW-1:0]      dramReadData,
  input  logic               dramValid,
  output logic [1:0]         grant_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state;
  logic [1:0] rr_ptr, pick;
  logic [AW-1:0] lat_addr, lat_wdata;
  logic lat_op, found, in_busy;
  logic [3:0] pend, pwe;
  logic [2:0] t;
  // padded to 4 bits so a 2-bit index is always in range regardless of N_REQ
  assign pend = 4'(req_re | req_we);
  assign pwe = 4'(req_we);
  // scan downward so the lowest offset from rr_ptr is the one that sticks
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    t = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      t = {1'b0, rr_ptr} + 3'(k);
      t = t >= 3'(N_REQ) ? t - 3'(N_REQ) : t;
      if (pend[t[1:0]]) begin
        pick = t[1:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_op <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_id <= pick;
          lat_addr <= req_addr[int'(pick)*AW +: AW];
          lat_wdata <= req_wdata[int'(pick)*AW +: AW];
          lat_op <= pwe[pick];
          state <= BUSY;
        end
        BUSY: if (dramValid) begin
          state <= RELEASE;
          rr_ptr <= grant_id == 2'(N_REQ - 1) ? 2'd0 : grant_id + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign in_busy = state == BUSY;
  assign dramAddress = in_busy ? lat_addr : '0;
  assign dramWriteData = in_busy ? lat_wdata : '0;
  assign dramWriteEnable = in_busy & lat_op;
  assign dramReadEnable = in_busy & ~lat_op;
  assign req_valid = (in_busy & dramValid) ? N_REQ'(1) << grant_id : '0;
  assign req_rdata = dramReadData;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scoreboard bench for dram_arbiter with N_REQ=2.
module tb_dram_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  logic clk = 0, reset = 1;
  logic [N*AW-1:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0] req_re = '0, req_we = '0, req_valid;
  logic [AW-1:0] req_rdata, dramAddress, dramWriteData, dramReadData = '0;
  logic dramReadEnable, dramWriteEnable, dramValid = 0, busy;
  logic [1:0] grant_id;
  int n = 0, fails = 0;
  typedef struct packed {logic [1:0] v; logic [31:0] d; logic [1:0] g;} exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  dram_arbiter #(.N_REQ(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_re(req_re), .req_we(req_we), .req_rdata(req_rdata), .req_valid(req_valid),
    .dramAddress(dramAddress), .dramWriteData(dramWriteData),
    .dramReadEnable(dramReadEnable), .dramWriteEnable(dramWriteEnable),
    .dramReadData(dramReadData), .dramValid(dramValid), .grant_id(grant_id), .busy(busy)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask
  task automatic expect_tx(input int g, input logic [31:0] d);
    q.push_back({2'(1 << g), d, 2'(g)});
  endtask
  always @(negedge clk) if (req_valid != 0) begin
    if (q.size() == 0) chk("unexpected_valid", 64'(req_valid), 0);
    else begin
      e = q.pop_front();
      chk("req_valid", 64'(req_valid), 64'(e.v));
      chk("req_rdata", 64'(req_rdata), 64'(e.d));
      chk("grant_at_valid", 64'(grant_id), 64'(e.g));
    end
  end
  task automatic wait_en;
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dramReadEnable | dramWriteEnable) break;
    end
    if (i == 20) chk("enable_timeout", 0, 1);
  endtask
  task automatic respond(input int lat, input logic [31:0] d, input int who);
    wait_en;
    repeat (lat) @(posedge clk);
    #1 dramValid = 1;
    dramReadData = d;
    @(posedge clk);
    #1 dramValid = 0;
    if (who >= 0) begin
      req_re[who] = 0;
      req_we[who] = 0;
    end
  endtask
  initial begin
    @(negedge clk);
    chk("rst_re", 64'(dramReadEnable), 0);
    chk("rst_we", 64'(dramWriteEnable), 0);
    chk("rst_addr", 64'(dramAddress), 0);
    chk("rst_valid", 64'(req_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant", 64'(grant_id), 0);
    @(posedge clk);
    #1 reset = 0;
    // single read from requester 1
    @(posedge clk);
    #1 req_addr[AW +: AW] = 32'h100;
    req_re = 2'b10;
    expect_tx(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_pre_re", 64'(dramReadEnable), 0);
    @(negedge clk);
    chk("rd_re", 64'(dramReadEnable), 1);
    chk("rd_we", 64'(dramWriteEnable), 0);
    chk("rd_addr", 64'(dramAddress), 64'h100);
    chk("rd_grant", 64'(grant_id), 1);
    chk("rd_busy", 64'(busy), 1);
    respond(5, 32'hDEADBEEF, 1);
    @(negedge clk);
    chk("release_busy", 64'(busy), 1);
    chk("release_en", 64'({dramReadEnable, dramWriteEnable}), 0);
    chk("release_valid", 64'(req_valid), 0);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);
    // simultaneous write 0 / read 1 from reset
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    req_addr = {32'h300, 32'h200};
    req_wdata = {32'h0, 32'h11112222};
    req_we = 2'b01;
    req_re = 2'b10;
    expect_tx(0, 32'h0);
    expect_tx(1, 32'hCAFE0001);
    wait_en;
    chk("sim0_grant", 64'(grant_id), 0);
    chk("sim0_we", 64'(dramWriteEnable), 1);
    chk("sim0_re", 64'(dramReadEnable), 0);
    chk("sim0_addr", 64'(dramAddress), 64'h200);
    chk("sim0_wdata", 64'(dramWriteData), 64'h11112222);
    respond(2, 32'h0, 0);
    @(negedge clk);
    chk("gap_release", 64'({dramReadEnable, dramWriteEnable}), 0);
    @(negedge clk);
    chk("gap_idle", 64'({dramReadEnable, dramWriteEnable}), 0);
    wait_en;
    chk("sim1_grant", 64'(grant_id), 1);
    chk("sim1_re", 64'(dramReadEnable), 1);
    chk("sim1_addr", 64'(dramAddress), 64'h300);
    respond(1, 32'hCAFE0001, 1);
    // continuous contention: 0,1,0,1,0,1
    req_re = 2'b11;
    for (int k = 0; k < 6; k++) begin
      expect_tx(k % 2, 32'hA0 + k);
      wait_en;
      chk("rr_grant", 64'(grant_id), 64'(k % 2));
      respond(1, 32'hA0 + k, -1);
    end
    req_re = 2'b00;
    // both read and write from requester 1: write wins
    req_re[1] = 1;
    req_we[1] = 1;
    expect_tx(1, 32'h55);
    wait_en;
    chk("both_we", 64'(dramWriteEnable), 1);
    chk("both_re", 64'(dramReadEnable), 0);
    chk("both_grant", 64'(grant_id), 1);
    respond(1, 32'h55, 1);
    // requester 0 drops its read two cycles into BUSY
    req_addr[0 +: AW] = 32'h400;
    req_re[0] = 1;
    expect_tx(0, 32'h77);
    wait_en;
    @(posedge clk);
    @(posedge clk);
    #1 req_re[0] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_re", 64'(dramReadEnable), 1);
      chk("drop_addr", 64'(dramAddress), 64'h400);
    end
    respond(1, 32'h77, -1);
    // reset during BUSY, then spurious dramValid
    req_addr[AW +: AW] = 32'h500;
    req_re[1] = 1;
    wait_en;
    chk("pre_rst_grant", 64'(grant_id), 1);
    @(posedge clk);
    #1 reset = 1;
    req_re = 2'b00;
    @(negedge clk);
    chk("midrst_re", 64'(dramReadEnable), 0);
    chk("midrst_addr", 64'(dramAddress), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_grant", 64'(grant_id), 0);
    dramValid = 1;
    dramReadData = 32'hBAD;
    @(negedge clk);
    chk("rst_spur_valid", 64'(req_valid), 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_spur_valid", 64'(req_valid), 0);
    chk("idle_spur_busy", 64'(busy), 0);
    @(posedge clk);
    #1 dramValid = 0;
    req_re = 2'b11;
    expect_tx(0, 32'h99);
    wait_en;
    chk("post_rst_grant", 64'(grant_id), 0);
    respond(1, 32'h99, -1);
    req_re = 2'b00;
    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
